aer_in_arbiter: RTL and testbench

AER_IN_ARBITER -- requirements
Module: aer_in_arbiter

---
 rtl/metis_aer_pkg.sv | 14 +
 rtl/aer_fifo.sv | 80 ++++++++
 rtl/aer_in_arbiter.sv | 125 ++++++++++++
 tb/tb_aer_in_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/metis_aer_pkg.sv
// Shared AER input definitions: per-channel handshake state and event record width.
package metis_aer_pkg;

    typedef enum logic {
        CH_IDLE  = 1'b0,
        CH_ACKED = 1'b1
    } ch_state_e;

    // Event record is {address, target flag, channel index}.
    function automatic int ev_rec_width(input int m, input int nch);
        return m + $clog2(nch) + 1;
    endfunction

endpackage

// File: rtl/aer_fifo.sv
// First-word-fall-through event FIFO with registered outputs.
// An entry becomes visible on dout one cycle after it is pushed; level counts
// every stored entry including the one currently presented on dout.
module aer_fifo
    import metis_aer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     valid,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_MAX = DEPTH;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [AW:0]      remain;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CNT_MAX);
    assign empty = (count_q == '0);
    assign level = count_q;
    assign dout  = dout_q;
    assign valid = valid_q;

    // Pointer/count update and selection of the next registered head entry.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        count_d  = count_q + (do_push ? CNT_ONE : '0) - (do_pop ? CNT_ONE : '0);
        // Only entries written before this edge may be presented, so a fresh
        // push never reaches dout in the same cycle; level 0 forces valid low.
        remain   = count_q - (do_pop ? CNT_ONE : '0);
        valid_d  = (remain != '0);
        dout_d   = valid_d ? mem_q[rd_ptr_d] : '0;
    end

    // Storage array; written only when space exists, so the head slot is never overwritten.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: rtl/aer_in_arbiter.sv
// Multi-channel AER input: synchronises 4-phase requests, round-robin grants one
// pending channel per cycle into an event FIFO, and acknowledges the granted channel.
module aer_in_arbiter
    import metis_aer_pkg::*;
#(
    parameter int M     = 8,
    parameter int NCH   = 4,
    parameter int DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NCH*M-1:0]         AERIN_ADDR,
    input  logic [NCH-1:0]           AERIN_REQ,
    output logic [NCH-1:0]           AERIN_ACK,
    input  logic [NCH-1:0]           AERIN_TAR_EN,
    input  logic [NCH-1:0]           CH_MASK,
    output logic                     EV_VALID,
    input  logic                     EV_READY,
    output logic [M-1:0]             EV_ADDR,
    output logic [$clog2(NCH)-1:0]   EV_CH,
    output logic                     EV_TAR,
    output logic [$clog2(DEPTH):0]   FIFO_LEVEL
);

    localparam int CW = $clog2(NCH);
    localparam int EW = ev_rec_width(M, NCH);
    localparam logic [CW:0]   NCH_W   = NCH;
    localparam logic [CW-1:0] CH_LAST = NCH - 1;
    localparam logic [CW-1:0] CH_ONE  = 1;

    logic [NCH-1:0] sync1_q, sync1_d;
    logic [NCH-1:0] sync2_q, sync2_d;
    ch_state_e      state_q [NCH];
    ch_state_e      state_d [NCH];
    logic [CW-1:0]  rr_q, rr_d;

    logic [NCH-1:0] pending;
    logic           grant_vld;
    logic [CW-1:0]  grant_ch;
    logic [CW:0]    arb_sum;
    logic [CW-1:0]  arb_idx;
    logic [EW-1:0]  push_rec;
    logic [EW-1:0]  fifo_dout;
    logic           fifo_full, fifo_empty, fifo_pop;

    // Two-stage request synchroniser; only sync2_q is used by the logic.
    always_comb begin
        sync1_d = AERIN_REQ;
        sync2_d = sync1_q;
    end

    // Round-robin search from rr_q; grants are withheld while the FIFO is full.
    always_comb begin
        for (int i = 0; i < NCH; i++)
            pending[i] = sync2_q[i] && (state_q[i] == CH_IDLE) && CH_MASK[i];
        grant_vld = 1'b0;
        grant_ch  = '0;
        arb_sum   = '0;
        arb_idx   = '0;
        for (int j = 0; j < NCH; j++) begin
            arb_sum = {1'b0, rr_q} + (CW+1)'(j);
            if (arb_sum >= NCH_W) arb_sum = arb_sum - NCH_W;
            arb_idx = arb_sum[CW-1:0];
            if (!grant_vld && pending[arb_idx] && !fifo_full) begin
                grant_vld = 1'b1;
                grant_ch  = arb_idx;
            end
        end
        rr_d = rr_q;
        if (grant_vld) rr_d = (grant_ch == CH_LAST) ? '0 : grant_ch + CH_ONE;
        push_rec = {AERIN_ADDR[grant_ch*M +: M], AERIN_TAR_EN[grant_ch], grant_ch};
    end

    // Per-channel handshake FSM: grant raises ACK, a synchronised REQ low drops it.
    // The mask only gates new grants, so an acknowledged channel always completes.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                CH_IDLE:  if (grant_vld && grant_ch == CW'(i)) state_d[i] = CH_ACKED;
                CH_ACKED: if (!sync2_q[i])                     state_d[i] = CH_IDLE;
                default:                                       state_d[i] = CH_IDLE;
            endcase
            AERIN_ACK[i] = (state_q[i] == CH_ACKED);
        end
    end

    // Synchroniser, channel state and round-robin pointer registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= '0;
            sync2_q <= '0;
            rr_q    <= '0;
            for (int i = 0; i < NCH; i++) state_q[i] <= CH_IDLE;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            rr_q    <= rr_d;
            for (int i = 0; i < NCH; i++) state_q[i] <= state_d[i];
        end
    end

    assign fifo_pop = EV_VALID && EV_READY && !fifo_empty;

    aer_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (grant_vld),
        .din   (push_rec),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .valid (EV_VALID),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (FIFO_LEVEL)
    );

    assign EV_ADDR = fifo_dout[EW-1 -: M];
    assign EV_TAR  = fifo_dout[CW];
    assign EV_CH   = fifo_dout[CW-1:0];

endmodule

// File: tb/tb_aer_in_arbiter.sv
// Directed bench for aer_in_arbiter (M=8, NCH=4, DEPTH=8).
module tb_aer_in_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] AERIN_ADDR;
    logic [3:0]  AERIN_REQ, AERIN_ACK, AERIN_TAR_EN, CH_MASK;
    logic        EV_VALID, EV_READY, EV_TAR;
    logic [7:0]  EV_ADDR;
    logic [1:0]  EV_CH;
    logic [3:0]  FIFO_LEVEL;

    int errors = 0;
    int checks = 0;

    logic [9:0] got [$];
    logic [9:0] exp_drain [9] = '{
        {2'd1, 8'h21}, {2'd2, 8'h22}, {2'd3, 8'h23},
        {2'd0, 8'h30}, {2'd1, 8'h31}, {2'd2, 8'h32}, {2'd3, 8'h33},
        {2'd0, 8'h40}, {2'd1, 8'h41}
    };

    aer_in_arbiter #(.M(8), .NCH(4), .DEPTH(8)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .AERIN_ADDR   (AERIN_ADDR),
        .AERIN_REQ    (AERIN_REQ),
        .AERIN_ACK    (AERIN_ACK),
        .AERIN_TAR_EN (AERIN_TAR_EN),
        .CH_MASK      (CH_MASK),
        .EV_VALID     (EV_VALID),
        .EV_READY     (EV_READY),
        .EV_ADDR      (EV_ADDR),
        .EV_CH        (EV_CH),
        .EV_TAR       (EV_TAR),
        .FIFO_LEVEL   (FIFO_LEVEL)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_addr(input logic [7:0] base);
        for (int i = 0; i < 4; i++) AERIN_ADDR[i*8 +: 8] = base + 8'(i);
    endtask

    task automatic chk_ev(input string tag, input logic [7:0] a, input logic [1:0] c, input logic t);
        chk({tag, "_valid"}, EV_VALID, 1);
        chk({tag, "_addr"},  EV_ADDR,  a);
        chk({tag, "_ch"},    EV_CH,    c);
        chk({tag, "_tar"},   EV_TAR,   t);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ack"},   AERIN_ACK,  0);
        chk({tag, "_valid"}, EV_VALID,   0);
        chk({tag, "_level"}, FIFO_LEVEL, 0);
        chk({tag, "_addr"},  EV_ADDR,    0);
        chk({tag, "_ch"},    EV_CH,      0);
        chk({tag, "_tar"},   EV_TAR,     0);
    endtask

    initial begin
        RST = 1'b1; AERIN_ADDR = '0; AERIN_REQ = '0; AERIN_TAR_EN = '0;
        CH_MASK = 4'hF; EV_READY = 1'b0;
        tick(2);
        chk_zero("reset");
        RST = 1'b0;
        tick();

        // Single uncontested event on channel 1.
        AERIN_ADDR[15:8] = 8'h5A; AERIN_TAR_EN = 4'b0010; EV_READY = 1'b1; AERIN_REQ = 4'b0010;
        tick(); chk("a_ack_e1", AERIN_ACK, 0);
        tick(); chk("a_ack_e2", AERIN_ACK, 0);
        tick(); chk("a_ack_e3", AERIN_ACK, 4'b0010); chk("a_valid_e3", EV_VALID, 0);
        tick(); chk_ev("a_ev", 8'h5A, 2'd1, 1'b1);
        AERIN_REQ = '0;
        tick(); chk("a_valid_popped", EV_VALID, 0); chk("a_level0", FIFO_LEVEL, 0);
        chk("a_ack_hold1", AERIN_ACK, 4'b0010);
        tick(); chk("a_ack_hold2", AERIN_ACK, 4'b0010);
        tick(); chk("a_ack_fall", AERIN_ACK, 0);

        // All four channels at once from RR=0.
        RST = 1'b1; #1;
        chk("b_rst_level", FIFO_LEVEL, 0);
        tick(); RST = 1'b0;
        AERIN_TAR_EN = '0; set_addr(8'h10); AERIN_REQ = 4'hF;
        tick(2); chk("b_ack_e2", AERIN_ACK, 0);
        tick();  chk("b_ack_e3", AERIN_ACK, 4'b0001);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_ev($sformatf("b_ev%0d", i), 8'h10 + 8'(i), 2'(i), 1'b0);
        end
        chk("b_ack_all", AERIN_ACK, 4'hF);
        chk("b_level_tail", FIFO_LEVEL, 1);
        tick(); chk("b_drained", EV_VALID, 0);
        AERIN_REQ = '0;
        tick(3); chk("b_ack_clear", AERIN_ACK, 0);

        // Fill the FIFO with backpressure; two more channels must be held off.
        EV_READY = 1'b0;
        set_addr(8'h20); AERIN_REQ = 4'hF;
        tick(8); chk("c_ack1", AERIN_ACK, 4'hF); chk("c_level4", FIFO_LEVEL, 4);
        AERIN_REQ = '0; tick(4); chk("c_ack_clr1", AERIN_ACK, 0);
        set_addr(8'h30); AERIN_REQ = 4'hF;
        tick(8); chk("c_ack2", AERIN_ACK, 4'hF); chk("c_level8", FIFO_LEVEL, 8);
        AERIN_REQ = '0; tick(4); chk("c_ack_clr2", AERIN_ACK, 0);
        set_addr(8'h40); AERIN_REQ = 4'b0011;
        tick(6); chk("c_held_ack", AERIN_ACK, 0); chk("c_held_level", FIFO_LEVEL, 8);
        chk_ev("c_head_stable", 8'h20, 2'd0, 1'b0);

        // One pop from full: no grant that cycle, grant on the next.
        EV_READY = 1'b1;
        tick(); chk("d_level7", FIFO_LEVEL, 7); chk("d_no_grant", AERIN_ACK, 0);
        chk_ev("d_next_head", 8'h21, 2'd1, 1'b0);
        EV_READY = 1'b0;
        tick(); chk("d_level8", FIFO_LEVEL, 8); chk("d_grant", AERIN_ACK, 4'b0001);

        // Drain everything and check grant order.
        EV_READY = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (EV_VALID && EV_READY) got.push_back({EV_CH, EV_ADDR});
            tick();
        end
        chk("d_drain_count", got.size(), 9);
        for (int i = 0; i < 9 && i < got.size(); i++)
            chk($sformatf("d_drain%0d", i), got[i], exp_drain[i]);
        chk("d_level_end", FIFO_LEVEL, 0);
        AERIN_REQ = '0; tick(4); chk("d_ack_clr", AERIN_ACK, 0);

        // Channel mask blocks grants but not an in-flight handshake.
        CH_MASK = 4'b1011; set_addr(8'h60); AERIN_REQ = 4'b0100;
        tick(8); chk("e_masked_ack", AERIN_ACK, 0); chk("e_masked_level", FIFO_LEVEL, 0);
        CH_MASK = 4'hF;
        tick(); chk("e_unmask_ack", AERIN_ACK, 4'b0100);
        tick(); chk_ev("e_ev", 8'h62, 2'd2, 1'b0);
        CH_MASK = 4'b1011;
        tick(2); chk("e_mask_acked", AERIN_ACK, 4'b0100);
        AERIN_REQ = '0;
        tick(3); chk("e_ack_fall", AERIN_ACK, 0);
        CH_MASK = 4'hF;

        // Reset mid-handshake with five buffered events.
        EV_READY = 1'b0; AERIN_TAR_EN = 4'hF; set_addr(8'h50); AERIN_REQ = 4'b0010;
        tick(6); chk("f_ack1", AERIN_ACK, 4'b0010);
        AERIN_REQ = '0; tick(4); chk("f_level1", FIFO_LEVEL, 1);
        AERIN_REQ = 4'hF;
        tick(8); chk("f_level5", FIFO_LEVEL, 5); chk("f_ack_all", AERIN_ACK, 4'hF);
        RST = 1'b1; #1;
        chk_zero("f_rst");
        tick(); RST = 1'b0;
        tick(); chk("f_re_e1", AERIN_ACK, 0);
        tick(); chk("f_re_e2", AERIN_ACK, 0);
        tick(); chk("f_re_e3", AERIN_ACK[0], 1);
        tick(); chk_ev("f_re_ev", 8'h50, 2'd0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
